// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the ALU writeback path
// and the memory-load writeback path. Arbitration is round-robin with
// valid/ready handshakes. The winner is accepted in the same cycle (the write
// port never stalls) and is presented to the register file one cycle later as
// a registered write command. A per-register pending-write scoreboard (busy)
// is kept for the issue stage's hazard detection.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   alu_valid  : ALU writeback request
//   alu_dst    : ALU destination register
//   alu_data   : ALU result
//   alu_ready  : ALU request accepted this cycle (combinational)
//   mem_valid  : load writeback request
//   mem_dst    : load destination register
//   mem_data   : load data
//   mem_ready  : load request accepted this cycle (combinational)
//   rsv_valid  : issue stage reserves a destination register
//   rsv_dst    : register being reserved
//   busy       : bit i set = write to register i pending (registered)
//   regwrite   : register-file write enable (registered)
//   wdst       : register-file write index (registered)
//   wdata      : register-file write data (registered)
//   grant_mem  : current write command came from the load path (registered)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RESET_PRIO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_dst,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_dst,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_dst,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      wdst,
    output logic [DATA_W-1:0]      wdata,
    output logic                   grant_mem
);

    localparam int NREG = 2**ADDR_W;

    // r_prio: 0 = ALU wins a tie, 1 = MEM wins a tie
    logic              r_prio;
    logic [NREG-1:0]   r_busy;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_wdst;
    logic [DATA_W-1:0] r_wdata;
    logic              r_grant_mem;

    logic              w_alu_win;
    logic              w_mem_win;
    logic              w_accept;
    logic [ADDR_W-1:0] w_dst;
    logic [DATA_W-1:0] w_data;
    logic [NREG-1:0]   w_busy_next;

    // Nothing is accepted while reset is held, so no request can slip through.
    assign w_alu_win = !rst && alu_valid && (!mem_valid || !r_prio);
    assign w_mem_win = !rst && mem_valid && (!alu_valid ||  r_prio);
    assign w_accept  = w_alu_win || w_mem_win;
    assign w_dst     = w_mem_win ? mem_dst  : alu_dst;
    assign w_data    = w_mem_win ? mem_data : alu_data;

    assign alu_ready = w_alu_win;
    assign mem_ready = w_mem_win;

    // Clear for the accepted write is applied first so a same-index
    // reservation in the same cycle overrides it: the new reservation
    // belongs to a younger instruction than the write retiring now.
    always_comb begin
        w_busy_next = r_busy;
        if (w_accept) begin
            w_busy_next[w_dst] = 1'b0;
        end
        if (rsv_valid) begin
            w_busy_next[rsv_dst] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'(RESET_PRIO);
            r_busy      <= '0;
            r_regwrite  <= 1'b0;
            r_wdst      <= '0;
            r_wdata     <= '0;
            r_grant_mem <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            // Register 0 is hardwired: the handshake completes but the
            // write enable is suppressed.
            r_regwrite <= w_accept && (w_dst != '0);
            if (w_accept) begin
                r_wdst      <= w_dst;
                r_wdata     <= w_data;
                r_grant_mem <= w_mem_win;
                // Hand priority to the requester that did not win.
                r_prio      <= w_alu_win;
            end
        end
    end

    assign busy      = r_busy;
    assign regwrite  = r_regwrite;
    assign wdst      = r_wdst;
    assign wdata     = r_wdata;
    assign grant_mem = r_grant_mem;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NREG       = 32;
    localparam int RESET_PRIO = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dst;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_dst;
    logic [NREG-1:0]   busy;
    logic              regwrite;
    logic [ADDR_W-1:0] wdst;
    logic [DATA_W-1:0] wdata;
    logic              grant_mem;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PRIO(RESET_PRIO)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_dst(rsv_dst), .busy(busy),
        .regwrite(regwrite), .wdst(wdst), .wdata(wdata), .grant_mem(grant_mem)
    );

    always #5 clk = ~clk;

    // Inputs applied during one cycle, expected ready in that cycle, and
    // expected registered outputs after the following rising edge.
    typedef struct {
        logic        rst;
        logic        av; logic [4:0] ad; logic [31:0] adat;
        logic        mv; logic [4:0] md; logic [31:0] mdat;
        logic        rv; logic [4:0] rd;
        logic        ear; logic emr;
        logic        erw; logic [4:0] ewdst; logic [31:0] ewdata; logic egm;
        logic [31:0] ebusy;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        alu_valid = v.av; alu_dst = v.ad; alu_data = v.adat;
        mem_valid = v.mv; mem_dst = v.md; mem_data = v.mdat;
        rsv_valid = v.rv; rsv_dst = v.rd;
    endtask

    // Behavioural reference: priority holder, pending-write set, last command.
    int          m_prio;
    bit          m_busy[NREG];
    bit          m_rw;
    int          m_wdst;
    logic [31:0] m_wdata;
    bit          m_gm;

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < NREG; i++) b[i] = m_busy[i];
        return b;
    endfunction

    initial begin
        vec_t v;
        int   win;
        int   dst;

        rst = 1'b1; alu_valid = 0; alu_dst = 0; alu_data = 0;
        mem_valid = 0; mem_dst = 0; mem_data = 0; rsv_valid = 0; rsv_dst = 0;

        //          rst av ad     adat          mv md     mdat          rv rd    ear emr  erw wdst   wdata         gm  busy
        tbl[0]  = '{1, 1, 5'd3,  32'h5,        1, 5'd4,  32'h6,        1, 5'd7,  0, 0,  0, 5'd0,  32'h0,        0, 32'h0};
        tbl[1]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0,  0, 5'd0,  32'h0,        0, 32'h0};
        tbl[2]  = '{0, 1, 5'd8,  32'hA,        0, 5'd0,  32'h0,        0, 5'd0,  1, 0,  1, 5'd8,  32'hA,        0, 32'h0};
        tbl[3]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0,  0, 5'd8,  32'hA,        0, 32'h0};
        tbl[4]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0,  0, 5'd0,  32'h0,        0, 32'h0};
        tbl[5]  = '{0, 1, 5'd9,  32'h99,       1, 5'd16, 32'h1616,     0, 5'd0,  1, 0,  1, 5'd9,  32'h99,       0, 32'h0};
        tbl[6]  = '{0, 1, 5'd9,  32'h99,       1, 5'd16, 32'h1616,     0, 5'd0,  0, 1,  1, 5'd16, 32'h1616,     1, 32'h0};
        tbl[7]  = '{0, 1, 5'd9,  32'h99,       1, 5'd16, 32'h1616,     0, 5'd0,  1, 0,  1, 5'd9,  32'h99,       0, 32'h0};
        tbl[8]  = '{0, 1, 5'd9,  32'h99,       1, 5'd16, 32'h1616,     0, 5'd0,  0, 1,  1, 5'd16, 32'h1616,     1, 32'h0};
        tbl[9]  = '{0, 0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  0, 1,  0, 5'd0,  32'hFFFFFFFF, 1, 32'h0};
        tbl[10] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd12, 0, 0,  0, 5'd0,  32'hFFFFFFFF, 1, 32'h00001000};
        tbl[11] = '{0, 1, 5'd12, 32'hC,        0, 5'd0,  32'h0,        0, 5'd0,  1, 0,  1, 5'd12, 32'hC,        0, 32'h0};
        tbl[12] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd19, 0, 0,  0, 5'd12, 32'hC,        0, 32'h00080000};
        tbl[13] = '{0, 0, 5'd0,  32'h0,        1, 5'd19, 32'h13,       1, 5'd19, 0, 1,  1, 5'd19, 32'h13,       1, 32'h00080000};
        tbl[14] = '{0, 1, 5'd19, 32'h14,       0, 5'd0,  32'h0,        1, 5'd5,  1, 0,  1, 5'd19, 32'h14,       0, 32'h00000020};
        tbl[15] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0,  0, 0,  0, 5'd19, 32'h14,       0, 32'h00000020};
        tbl[16] = '{0, 0, 5'd0,  32'h0,        1, 5'd10, 32'h10,       0, 5'd0,  0, 1,  1, 5'd10, 32'h10,       1, 32'h00000020};
        tbl[17] = '{1, 1, 5'd7,  32'h77,       1, 5'd7,  32'h78,       1, 5'd7,  0, 0,  0, 5'd0,  32'h0,        0, 32'h0};
        tbl[18] = '{0, 1, 5'd2,  32'h22,       0, 5'd0,  32'h0,        0, 5'd0,  1, 0,  1, 5'd2,  32'h22,       0, 32'h0};
        tbl[19] = '{1, 1, 5'd2,  32'h22,       1, 5'd3,  32'h33,       0, 5'd0,  0, 0,  0, 5'd0,  32'h0,        0, 32'h0};
        tbl[20] = '{0, 1, 5'd2,  32'h22,       1, 5'd3,  32'h33,       0, 5'd0,  1, 0,  1, 5'd2,  32'h22,       0, 32'h0};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].ear));
            chk($sformatf("vec%0d mem_ready", i), 32'(mem_ready), 32'(tbl[i].emr));
            @(posedge clk); #1;
            chk($sformatf("vec%0d regwrite", i),  32'(regwrite),  32'(tbl[i].erw));
            chk($sformatf("vec%0d wdst", i),      32'(wdst),      32'(tbl[i].ewdst));
            chk($sformatf("vec%0d wdata", i),     wdata,          tbl[i].ewdata);
            chk($sformatf("vec%0d grant_mem", i), 32'(grant_mem), 32'(tbl[i].egm));
            chk($sformatf("vec%0d busy", i),      busy,           tbl[i].ebusy);
        end

        // Randomized phase against the reference model; first cycle is a reset.
        for (int c = 0; c < 600; c++) begin
            v.rst  = (c == 0) || ($urandom_range(0, 39) == 0);
            v.av   = ($urandom_range(0, 2) != 0);
            v.ad   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.adat = $urandom;
            v.mv   = ($urandom_range(0, 2) != 0);
            v.md   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.mdat = $urandom;
            v.rv   = ($urandom_range(0, 1) != 0);
            case ($urandom_range(0, 3))
                0:       v.rd = v.ad;
                1:       v.rd = v.md;
                default: v.rd = 5'($urandom_range(0, 31));
            endcase
            drive(v);

            win = -1;
            if (!v.rst) begin
                if (v.av && v.mv) win = m_prio;
                else if (v.av)    win = 0;
                else if (v.mv)    win = 1;
            end

            @(negedge clk);
            chk("rand alu_ready", 32'(alu_ready), 32'(win == 0));
            chk("rand mem_ready", 32'(mem_ready), 32'(win == 1));
            @(posedge clk); #1;

            if (v.rst) begin
                m_prio = RESET_PRIO; m_rw = 0; m_wdst = 0; m_wdata = '0; m_gm = 0;
                for (int i = 0; i < NREG; i++) m_busy[i] = 0;
            end else begin
                m_rw = 0;
                if (win >= 0) begin
                    dst     = (win == 1) ? int'(v.md) : int'(v.ad);
                    m_rw    = (dst != 0);
                    m_wdst  = dst;
                    m_wdata = (win == 1) ? v.mdat : v.adat;
                    m_gm    = (win == 1);
                    m_prio  = 1 - win;
                    m_busy[dst] = 0;
                end
                if (v.rv && v.rd != 0) m_busy[v.rd] = 1;
            end

            chk("rand regwrite",  32'(regwrite),  32'(m_rw));
            chk("rand wdst",      32'(wdst),      32'(m_wdst));
            chk("rand wdata",     wdata,          m_wdata);
            chk("rand grant_mem", 32'(grant_mem), 32'(m_gm));
            chk("rand busy",      busy,           model_busy());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
